// File: rtl/mips_data_mem_responder.sv
// Data-memory responder for the single-cycle MIPS datapath: word-wide block RAM behind a
// MemRead/MemWrite request, Done handshake. Define MEM_ERR_EN to flag misaligned/conflicting requests.
module mips_data_mem_responder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              Busy,
    output logic              Done,
    output logic              MemErr
);
    localparam int IDX_W = ADDR_W - 2;
    localparam int WORDS = 2 ** IDX_W;

    typedef enum logic [1:0] {IDLE, RD_WAIT, DONE} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_err;
    logic [DATA_W-1:0] r_read_data;
    logic              r_busy;
    logic              r_done;
    logic              r_mem_err;
    logic              w_busy_next;
    logic              w_done_next;
    logic              w_err_next;

    logic [DATA_W-1:0] r_ram [WORDS];
    logic [DATA_W-1:0] r_ram_q;

    logic [IDX_W-1:0]  w_word;
    logic [IDX_W-1:0]  w_rd_idx;
    logic              w_req;
    logic              w_accept_err;
    logic              w_do_write;

    assign w_word = Addr[ADDR_W-1:2];
    assign w_req  = MemRead | MemWrite;

`ifdef MEM_ERR_EN
    assign w_accept_err = w_req & ((MemRead & MemWrite) | (Addr[1:0] != 2'b00));
`else
    logic w_unused_addr_lsb;
    assign w_unused_addr_lsb = ^Addr[1:0];
    assign w_accept_err      = 1'b0;
`endif

    assign w_do_write = (r_state == IDLE) && MemWrite && !w_accept_err;

    // While idle the RAM port follows the live address so the word is already in r_ram_q
    // one edge after accept; afterwards it tracks the latched index.
    assign w_rd_idx = (r_state == IDLE) ? w_word : r_idx;

    always_ff @(posedge CLK) begin
        if (w_do_write) begin
            r_ram[w_word] <= WriteData;
        end
        r_ram_q <= r_ram[w_rd_idx];
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept_err || MemWrite) begin
                    w_state_next = DONE;
                end else if (MemRead) begin
                    w_state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs are registered from the current state, so they trail the state by one edge.
    always_comb begin
        w_busy_next = (r_state != IDLE);
        w_done_next = (r_state == DONE);
        w_err_next  = (r_state == DONE) && r_err;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_idx       <= '0;
            r_err       <= 1'b0;
            r_read_data <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_err   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
            r_mem_err <= w_err_next;
            if (r_state == IDLE) begin
                r_idx <= w_word;
                r_err <= w_accept_err;
                r_cnt <= 4'(RD_LAT - 1);
            end else if (r_state == RD_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == RD_WAIT && r_cnt == 4'd0) begin
                r_read_data <= r_ram_q;
            end
        end
    end

    assign ReadData = r_read_data;
    assign Busy     = r_busy;
    assign Done     = r_done;
    assign MemErr   = r_mem_err;

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Directed plus randomized bench for mips_data_mem_responder against a word-array reference model.
module tb_mips_data_mem_responder;
    localparam int RD_LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [9:0]  Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Busy;
    logic        Done;
    logic        MemErr;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [31:0] model [256];
    logic [31:0] exp_rdata;

    mips_data_mem_responder #(.DATA_W(32), .ADDR_W(10), .RD_LAT(RD_LAT)) dut (
        .CLK       (clk),
        .Reset     (rst_n),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Busy      (Busy),
        .Done      (Done),
        .MemErr    (MemErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int exp_lat, input string tag);
        int lat;
        lat = 0;
        while (Done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "/lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic access(input bit rd, input bit wr, input logic [9:0] a,
                          input logic [31:0] d, input string tag);
        int idx;
        bit err;
        int lat_exp;
        idx = int'(a[9:2]);
`ifdef MEM_ERR_EN
        err = (rd && wr) || (a[1:0] != 2'b00);
`else
        err = 1'b0;
`endif
        if (err || wr) begin
            lat_exp = 1;
            if (!err) model[idx] = d;
        end else begin
            lat_exp   = RD_LAT + 1;
            exp_rdata = model[idx];
        end
        @(negedge clk);
        MemRead = rd; MemWrite = wr; Addr = a; WriteData = d;
        @(posedge clk); #1;
        Addr      = 10'($urandom);
        WriteData = $urandom;
        wait_done(lat_exp, tag);
        chk({tag, "/rdata"}, ReadData, exp_rdata);
        chk({tag, "/err"}, 32'(MemErr), 32'(err));
        chk({tag, "/busy_done"}, 32'(Busy), 32'd1);
        MemRead = 1'b0; MemWrite = 1'b0;
        @(posedge clk); #1;
        chk({tag, "/done_pulse"}, 32'(Done), 32'd0);
        chk({tag, "/busy_after"}, 32'(Busy), 32'd0);
        $display("txn %s rd=%0b wr=%0b addr=%h rdata=%h err=%0b", tag, rd, wr, a, ReadData, MemErr);
    endtask

    initial begin
        bit saw_done;
        rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Addr = '0; WriteData = '0;
        exp_rdata = 32'd0;
        #2;
        chk("rst/rdata", ReadData, 32'd0);
        chk("rst/busy", 32'(Busy), 32'd0);
        chk("rst/done", 32'(Done), 32'd0);
        chk("rst/err", 32'(MemErr), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic write then read
        access(1'b0, 1'b1, 10'h010, 32'hDEADBEEF, "t2_wr");
        access(1'b1, 1'b0, 10'h010, 32'h0, "t2_rd");
        chk("t2/value", ReadData, 32'hDEADBEEF);

        // Asynchronous reset while idle
        @(negedge clk); #2;
        rst_n = 1'b0; #1;
        exp_rdata = 32'd0;
        chk("t1/rdata", ReadData, 32'd0);
        chk("t1/busy", 32'(Busy), 32'd0);
        chk("t1/done", 32'(Done), 32'd0);
        chk("t1/err", 32'(MemErr), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Back-to-back reads with the request held through Done
        access(1'b0, 1'b1, 10'h3FC, 32'h11111111, "t3_wr_hi");
        access(1'b0, 1'b1, 10'h000, 32'h22222222, "t3_wr_lo");
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b0; Addr = 10'h3FC;
        @(posedge clk); #1;
        wait_done(RD_LAT + 1, "t3_rd1");
        chk("t3_rd1/rdata", ReadData, 32'h11111111);
        Addr = 10'h000;
        @(posedge clk); #1;
        chk("t3/busy_gap", 32'(Busy), 32'd0);
        chk("t3/done_gap", 32'(Done), 32'd0);
        @(posedge clk); #1;
        chk("t3/busy_again", 32'(Busy), 32'd1);
        wait_done(RD_LAT, "t3_rd2");
        chk("t3_rd2/rdata", ReadData, 32'h22222222);
        MemRead = 1'b0;
        exp_rdata = 32'h22222222;
        @(posedge clk); #1;
        chk("t3/busy_end", 32'(Busy), 32'd0);
        $display("txn t3 held reads rdata=%h", ReadData);

        // Reset during RD_WAIT abandons the read
        @(negedge clk);
        MemRead = 1'b1; Addr = 10'h010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        MemRead = 1'b0;
        exp_rdata = 32'd0;
        chk("t4/rdata", ReadData, 32'd0);
        chk("t4/busy", 32'(Busy), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (Done === 1'b1) saw_done = 1'b1;
        end
        chk("t4/no_done", 32'(saw_done), 32'd0);
        chk("t4/rdata_hold", ReadData, 32'd0);
        $display("txn t4 reset mid-read rdata=%h", ReadData);
        access(1'b1, 1'b0, 10'h010, 32'h0, "t4_rd");
        chk("t4/retained", ReadData, 32'hDEADBEEF);

        // Conflicting request and misaligned read
        access(1'b0, 1'b1, 10'h020, 32'h0BADF00D, "t5_pre");
        access(1'b1, 1'b1, 10'h020, 32'hA5A5A5A5, "t5_both");
        access(1'b1, 1'b0, 10'h020, 32'h0, "t5_chk");
        access(1'b1, 1'b0, 10'h011, 32'h0, "t6_mis");

        // Randomized traffic over a small window of words
        for (int w = 0; w < 8; w++) begin
            access(1'b0, 1'b1, 10'(w * 4), $urandom, "rnd_init");
        end
        for (int n = 0; n < 24; n++) begin
            int w;
            bit rd;
            bit wr;
            logic [1:0] lo;
            w  = int'($urandom_range(0, 7));
            rd = 1'($urandom_range(0, 1));
            wr = !rd || ($urandom_range(0, 3) == 0);
            lo = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            access(rd, wr, {8'(w), lo}, $urandom, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
